isram_arbiter: RTL



---
 rtl/isram_arbiter_if.sv | 39 +++
 rtl/isram_arbiter.sv | 98 +++++++++
 2 files changed

// File: rtl/isram_arbiter_if.sv
// Bus bundle between the ISRAM arbiter, fetch (genpc), the LSU and the SRAM macro.
// The slave modport is the arbiter's view; master is the requester/SRAM side.
interface isram_arbiter_if;
  logic        fe_cs;
  logic [31:3] fe_adr;
  logic [63:0] fe_rdata;
  logic        fe_rvalid;

  logic        ls_req;
  logic        ls_we;
  logic [31:2] ls_adr;
  logic [3:0]  ls_be;
  logic [31:0] ls_wdata;
  logic        ls_gnt;
  logic        ls_rvalid;
  logic [31:0] ls_rdata;

  logic        lr_isram_cs;
  logic        lr_isram_cs_endp;

  logic        isram_cs;
  logic        isram_we;
  logic [31:3] isram_adr;
  logic [7:0]  isram_wem;
  logic [63:0] isram_wdata;
  logic [63:0] isram_rdata;

  modport slave (
    input  fe_cs, fe_adr, ls_req, ls_we, ls_adr, ls_be, ls_wdata, isram_rdata,
    output fe_rdata, fe_rvalid, ls_gnt, ls_rvalid, ls_rdata, lr_isram_cs, lr_isram_cs_endp,
           isram_cs, isram_we, isram_adr, isram_wem, isram_wdata
  );

  modport master (
    output fe_cs, fe_adr, ls_req, ls_we, ls_adr, ls_be, ls_wdata, isram_rdata,
    input  fe_rdata, fe_rvalid, ls_gnt, ls_rvalid, ls_rdata, lr_isram_cs, lr_isram_cs_endp,
           isram_cs, isram_we, isram_adr, isram_wem, isram_wdata
  );
endinterface

// File: rtl/isram_arbiter.sv
// Single-port ISRAM arbiter: LSU has priority over fetch, with a burst cap that forces one
// fetch slot and a refetch pulse to genpc after every LSU burst.
module isram_arbiter #(
  parameter int unsigned MAX_LS_BURST = 4
) (
  input  logic          clk,
  input  logic          cpurst,
  isram_arbiter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StLsBusy, StRefill} state_e;

  localparam logic [4:0] MaxBurst = 5'(MAX_LS_BURST);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [4:0]  cnt_inc;
  logic        ls_gnt;
  logic        rd_pend_q;
  logic        sel_q;
  logic        fe_rvalid_q;

  assign ls_gnt  = bus.ls_req & ~cpurst & (state_q != StRefill);
  assign cnt_inc = {1'b0, cnt_q} + 5'd1;

  // State register
  always_ff @(posedge clk) begin
    if (cpurst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state; IDLE and LS_BUSY share the grant path since cnt_q is 0 in IDLE
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle, StLsBusy: begin
        if (ls_gnt) begin
          cnt_d   = cnt_inc[3:0];
          state_d = (cnt_inc >= MaxBurst) ? StRefill : StLsBusy;
        end else begin
          cnt_d   = '0;
          state_d = StIdle;
        end
      end
      StRefill: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
      default: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
    endcase
  end

  // Outputs: SRAM mux, stall and refetch pulse
  always_comb begin
    bus.ls_gnt           = ls_gnt;
    bus.lr_isram_cs      = ls_gnt;
    bus.lr_isram_cs_endp = ~cpurst & (((state_q == StLsBusy) & ~ls_gnt) | (state_q == StRefill));
    bus.isram_cs         = ls_gnt | bus.fe_cs;
    bus.isram_wdata      = {bus.ls_wdata, bus.ls_wdata};
    bus.isram_adr        = bus.fe_adr;
    bus.isram_we         = 1'b0;
    bus.isram_wem        = 8'h00;
    if (ls_gnt) begin
      bus.isram_adr = bus.ls_adr[31:3];
      bus.isram_we  = bus.ls_we;
      if (bus.ls_we) begin
        bus.isram_wem = bus.ls_adr[2] ? {bus.ls_be, 4'h0} : {4'h0, bus.ls_be};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (cpurst) begin
      rd_pend_q   <= 1'b0;
      sel_q       <= 1'b0;
      fe_rvalid_q <= 1'b0;
    end else begin
      rd_pend_q   <= ls_gnt & ~bus.ls_we;
      sel_q       <= bus.ls_adr[2];
      fe_rvalid_q <= bus.isram_cs & ~ls_gnt;
    end
  end

  assign bus.ls_rvalid = rd_pend_q;
  assign bus.ls_rdata  = sel_q ? bus.isram_rdata[63:32] : bus.isram_rdata[31:0];
  assign bus.fe_rvalid = fe_rvalid_q;
  assign bus.fe_rdata  = bus.isram_rdata;

endmodule
